// File: rtl/mul_accumulate_unit.sv
// Multiply-accumulate back end: sums a programmed count of multiplier products.
// The MAC_SATURATE_EN macro makes the accumulator clamp on overflow instead of wrapping.
module mul_accumulate_unit #(
   parameter int PROD_W = 16,
   parameter int ACC_W  = 24,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  res,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              ovf,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;
   logic [ACC_W-1:0]  acc_r;
   logic [LEN_W-1:0]  rem_r;
   logic              ovf_r;
   logic              prod_ready_r;
   logic              res_valid_r;
   logic              busy_r;

   logic              beat_s;
   logic [ACC_W:0]    sum_s;
   logic              carry_s;
   logic [ACC_W-1:0]  acc_add_s;

   assign beat_s  = prod_valid & prod_ready_r;
   assign sum_s   = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
   assign carry_s = sum_s[ACC_W];

   // Overflow policy for the accumulator update
   always_comb begin
      acc_add_s = sum_s[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
      if (carry_s) begin
         acc_add_s = {ACC_W{1'b1}};
      end else begin
         acc_add_s = sum_s[ACC_W-1:0];
      end
`else
      acc_add_s = sum_s[ACC_W-1:0];
`endif
   end

   // Next-state decode; abort outranks every other event outside IDLE
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (abort) begin
               state_nx_s = IDLE;
            end else if (start) begin
               if (len != {LEN_W{1'b0}}) begin
                  state_nx_s = ACCUM;
               end else begin
                  state_nx_s = DONE;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         ACCUM: begin
            if (abort) begin
               state_nx_s = IDLE;
            end else if (beat_s && (rem_r == {{(LEN_W-1){1'b0}}, 1'b1})) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = ACCUM;
            end
         end
         DONE: begin
            if (abort) begin
               state_nx_s = IDLE;
            end else if (res_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State register with outputs decoded from the next state so they come straight from flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         prod_ready_r <= 1'b0;
         res_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         prod_ready_r <= (state_nx_s == ACCUM);
         res_valid_r  <= (state_nx_s == DONE);
         busy_r       <= (state_nx_s != IDLE);
      end
   end

   // Accumulator, beat counter and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= {ACC_W{1'b0}};
         rem_r <= {LEN_W{1'b0}};
         ovf_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!abort && start) begin
                  acc_r <= {ACC_W{1'b0}};
                  rem_r <= len;
                  ovf_r <= 1'b0;
               end
            end
            ACCUM: begin
               if (abort) begin
                  acc_r <= {ACC_W{1'b0}};
                  rem_r <= {LEN_W{1'b0}};
                  ovf_r <= 1'b0;
               end else if (beat_s && (rem_r != {LEN_W{1'b0}})) begin
                  acc_r <= acc_add_s;
                  rem_r <= rem_r - {{(LEN_W-1){1'b0}}, 1'b1};
                  ovf_r <= ovf_r | carry_s;
               end
            end
            DONE: begin
               if (abort) begin
                  acc_r <= {ACC_W{1'b0}};
                  rem_r <= {LEN_W{1'b0}};
                  ovf_r <= 1'b0;
               end
            end
            default: begin
               acc_r <= {ACC_W{1'b0}};
               rem_r <= {LEN_W{1'b0}};
               ovf_r <= 1'b0;
            end
         endcase
      end
   end

   assign prod_ready = prod_ready_r;
   assign res_valid  = res_valid_r;
   assign busy       = busy_r;
   assign res        = acc_r;
   assign ovf        = ovf_r;

endmodule

// File: doc/mul_accumulate_unit.md
Name: mul_accumulate_unit

Overview:
- Downstream consumer of the 8x8 array multiplier. Accepts a stream of 16-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Presents the final sum to the ALU result path over a second valid/ready handshake.
- Provides the multiply-accumulate (dot-product) operation of the 8-bit ALU, which the combinational multiplier alone cannot provide.

Parameters:
- PROD_W, 16, width of each incoming product (full 16-bit multiplier result).
- ACC_W, 24, accumulator and result width; must be >= PROD_W.
- LEN_W, 8, width of the beat-count field.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin an accumulation; honoured only in IDLE.
- len  input  LEN_W  number of products to accumulate; sampled with start.
- abort  input  1  cancel the current operation; returns to IDLE.
- prod  input  PROD_W  product from the multiplier (unsigned).
- prod_valid  input  1  prod is valid this cycle.
- prod_ready  output  1  block accepts prod this cycle.
- res  output  ACC_W  accumulated result.
- res_valid  output  1  res is final.
- res_ready  input  1  downstream accepts res.
- ovf  output  1  accumulation exceeded ACC_W bits.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCUM, DONE.
- Reset (synchronous, active-high): state=IDLE, acc=0, remaining=0, ovf=0. Outputs prod_ready=0, res_valid=0, res=0, busy=0. Reset mid-operation discards all progress.

IDLE:
- prod_ready=0, res_valid=0.
- start=1 clears acc and ovf and loads remaining=len.
- Next state is ACCUM if len!=0; if len==0, next state is DONE directly with res=0.

ACCUM:
- prod_ready=1 (registered state decode, no combinational path from prod_valid).
- A beat occurs when prod_valid & prod_ready. On each beat: acc <= acc + zero-extended prod, mod 2^ACC_W; remaining <= remaining-1.
- A carry out of bit ACC_W-1 sets ovf. ovf is sticky until the next accepted start.
- On the beat where remaining==1, next state is DONE; the updated acc is visible in DONE the following cycle.
- prod_valid low: no change and no timeout; the block waits indefinitely.

DONE:
- res_valid=1, res=acc, held stable while res_ready=0. prod_ready=0.
- res_ready=1 gives next state IDLE; res_valid drops the next cycle. res and ovf keep their last values in IDLE until the next start.

Boundary rules:
- start outside IDLE is ignored; no state change.
- abort has priority over every other event in ACCUM and DONE: next state IDLE, acc=0, ovf=0. A beat coinciding with abort is dropped, and res_valid is not asserted.
- abort in IDLE is a no-op. abort and start asserted together in IDLE: abort wins, start is ignored.
- Throughput: one product per cycle in ACCUM. Latency from the final beat to res_valid is 1 cycle.
- len==2^LEN_W-1 is legal; remaining never wraps because it is only decremented on beats while nonzero.

Optional Feature:
- Macro: MAC_SATURATE_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays there for the remaining beats; ovf sets as normal.
- Undefined: acc wraps modulo 2^ACC_W, and ovf is the only indication of overflow.

Test Plan:
- Basic accumulation: reset, then start with len=3; products 0x0006, 0x00FF, 0x1000 on consecutive cycles; res_ready=1. Required: res_valid one cycle after the 3rd beat, res=0x001105, ovf=0, back to IDLE the next cycle.
- Zero length: start with len=0. Required: DONE the next cycle, res=0, res_valid=1, prod_ready never asserted.
- Backpressure and bubbles: len=2, prod_valid toggles 1,0,0,1 with prod=0xFFFF; res_ready held 0 for 4 cycles. Required: res=0x01FFFE held stable with res_valid=1 until res_ready=1; exactly 2 beats counted.
- Overflow (ACC_W=16 override): len=2, products 0xFFFF and 0x0002. Required: ovf=1 and res=0x0001 without MAC_SATURATE_EN; res=0xFFFF with MAC_SATURATE_EN.
- Abort: len=4, abort asserted on the 2nd beat together with prod_valid. Required: IDLE the next cycle, acc=0, res_valid never asserted. A following start with len=1 and prod=0x0005 gives res=0x000005.
- Reset and ignored start: rst asserted in ACCUM after 1 beat. Required: all outputs at reset values the next cycle. A start asserted during DONE is ignored: state and res are unchanged.
